// File: rtl/uart_pkg.sv
// Shared types and ASCII constants for the UART command controller.
// Reply lengths are in bytes; a read reply adds CRLF_LEN to its hex chars.
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        R_OK,
        R_ER,
        R_TO,
        R_RD
    } reply_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_O  = 8'h4F;
    localparam logic [7:0] ASCII_K  = 8'h4B;
    localparam logic [7:0] ASCII_E  = 8'h45;
    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_T  = 8'h54;

    localparam int REPLY_FIX_LEN = 4;
    localparam int CRLF_LEN      = 2;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit value to uppercase ASCII hex digit.
module nibble_to_ascii (
    input  logic [3:0] i_nib,
    output logic [7:0] o_char
);

    always_comb begin
        if (i_nib < 4'd10) begin
            o_char = 8'h30 + {4'd0, i_nib};
        end else begin
            o_char = 8'h37 + {4'd0, i_nib};
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Runs one decoded UART command on the register bus and
// streams the ASCII reply to the transmitter.
module uart_cmd_ctrl
    import uart_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    input  logic              i_cmd_wr,
    input  logic              i_cmd_rd,
    input  logic              i_cmd_fail,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_data,
    output logic              o_reg_req,
    output logic              o_reg_we,
    output logic [ADDR_W-1:0] o_reg_addr,
    output logic [DATA_W-1:0] o_reg_wdata,
    input  logic              i_reg_ack,
    input  logic [DATA_W-1:0] i_reg_rdata,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_busy,
    output logic              o_cmd_drop
);

    localparam int NHEX   = DATA_W / 4;
    localparam int RD_LEN = NHEX + CRLF_LEN;
    localparam int IDX_W  = $clog2(RD_LEN);
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

    state_t              r_state;
    state_t              w_next;
    logic                r_pend;
    logic                r_wr;
    logic                r_rd;
    logic                r_fail;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    reply_t              r_reply;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic                r_drop;

    logic                w_bad;
    logic                w_cnt_exp;
    logic [IDX_W-1:0]    w_len_m1;
    logic [3:0]          w_nib;
    logic [7:0]          w_hex;
    logic [7:0]          w_byte;

    assign w_bad     = r_fail | (r_wr == r_rd);
    assign w_cnt_exp = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_len_m1  = (r_reply == R_RD) ? IDX_W'(RD_LEN - 1)
                                         : IDX_W'(REPLY_FIX_LEN - 1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // r_pend marks the decision cycle spent in IDLE after a command is latched
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (r_pend) begin
                    w_next = w_bad ? S_RESP : S_BUS;
                end
            end
            S_BUS: begin
                if (i_reg_ack || w_cnt_exp) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (i_tx_ready && (r_idx == w_len_m1)) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_reg_req   = (r_state == S_BUS);
        o_reg_we    = o_reg_req & r_wr;
        o_reg_addr  = r_addr;
        o_reg_wdata = r_wdata;
        o_tx_valid  = (r_state == S_RESP);
        o_tx_data   = o_tx_valid ? w_byte : 8'h00;
        o_busy      = (r_state != S_IDLE) | r_pend;
        o_cmd_drop  = r_drop;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend  <= 1'b0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_fail  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_reply <= R_OK;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= i_cmd_valid & o_busy;
            if (r_state == S_IDLE && !r_pend && i_cmd_valid) begin
                r_pend  <= 1'b1;
                r_wr    <= i_cmd_wr;
                r_rd    <= i_cmd_rd;
                r_fail  <= i_cmd_fail;
                r_addr  <= i_cmd_addr;
                r_wdata <= i_cmd_data;
            end
            if (r_state == S_IDLE && r_pend) begin
                r_pend <= 1'b0;
                r_cnt  <= '0;
                r_idx  <= '0;
                if (w_bad) begin
                    r_reply <= R_ER;
                end
            end
            if (r_state == S_BUS) begin
                if (i_reg_ack) begin
                    r_reply <= r_wr ? R_OK : R_RD;
                    if (!r_wr) begin
                        r_rdata <= i_reg_rdata;
                    end
                end else if (w_cnt_exp) begin
                    r_reply <= R_TO;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            if (r_state == S_RESP && i_tx_ready) begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    // Byte index 0 selects the most significant nibble
    always_comb begin
        w_nib = 4'h0;
        for (int k = 0; k < NHEX; k++) begin
            if (r_idx == IDX_W'(NHEX - 1 - k)) begin
                w_nib = r_rdata[k*4 +: 4];
            end
        end
    end

    nibble_to_ascii u_hex (
        .i_nib  (w_nib),
        .o_char (w_hex)
    );

    always_comb begin
        w_byte = 8'h00;
        if (r_reply == R_RD) begin
            if (r_idx < IDX_W'(NHEX)) begin
                w_byte = w_hex;
            end else if (r_idx == IDX_W'(NHEX)) begin
                w_byte = ASCII_CR;
            end else begin
                w_byte = ASCII_LF;
            end
        end else begin
            case (r_idx)
                IDX_W'(0): begin
                    unique case (r_reply)
                        R_ER:    w_byte = ASCII_E;
                        R_TO:    w_byte = ASCII_T;
                        default: w_byte = ASCII_O;
                    endcase
                end
                IDX_W'(1): begin
                    unique case (r_reply)
                        R_ER:    w_byte = ASCII_R;
                        R_TO:    w_byte = ASCII_O;
                        default: w_byte = ASCII_K;
                    endcase
                end
                IDX_W'(2): w_byte = ASCII_CR;
                default:   w_byte = ASCII_LF;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomized scoreboard bench for uart_cmd_ctrl.
module tb_uart_cmd_ctrl;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_wr = 1'b0;
    logic          cmd_rd = 1'b0;
    logic          cmd_fail = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          req;
    logic          we;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic          ack = 1'b0;
    logic [DW-1:0] rdata_in = '0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic          busy;
    logic          cmd_drop;

    int n_tests = 0;
    int n_fail = 0;
    int ready_pct = 100;
    byte unsigned exp_q[$];

    always #5 clk = ~clk;

    uart_cmd_ctrl #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_cmd_valid(cmd_valid),
        .i_cmd_wr(cmd_wr),
        .i_cmd_rd(cmd_rd),
        .i_cmd_fail(cmd_fail),
        .i_cmd_addr(cmd_addr),
        .i_cmd_data(cmd_data),
        .o_reg_req(req),
        .o_reg_we(we),
        .o_reg_addr(reg_addr),
        .o_reg_wdata(reg_wdata),
        .i_reg_ack(ack),
        .i_reg_rdata(rdata_in),
        .o_tx_data(tx_data),
        .o_tx_valid(tx_valid),
        .i_tx_ready(tx_ready),
        .o_busy(busy),
        .o_cmd_drop(cmd_drop)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference reply: plain text per outcome, read data as hex digits
    task automatic push_reply(input bit bus, input bit wr, input int delay,
                              input logic [DW-1:0] rd);
        string txt;
        string hexs;
        hexs = "0123456789ABCDEF";
        if (!bus) txt = "ER\r\n";
        else if (delay >= TO) txt = "TO\r\n";
        else if (wr) txt = "OK\r\n";
        else begin
            for (int i = DW/4 - 1; i >= 0; i--) begin
                exp_q.push_back(hexs[int'(rd[i*4 +: 4])]);
            end
            txt = "\r\n";
        end
        for (int i = 0; i < txt.len(); i++) exp_q.push_back(txt[i]);
    endtask

    task automatic scramble_cmd();
        cmd_wr   = 1'($urandom);
        cmd_rd   = 1'($urandom);
        cmd_fail = 1'($urandom);
        cmd_addr = AW'($urandom);
        cmd_data = $urandom;
    endtask

    task automatic pulse_cmd(input bit wr, input bit rd, input bit fail,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1'b1;
        cmd_wr = wr;
        cmd_rd = rd;
        cmd_fail = fail;
        cmd_addr = a;
        cmd_data = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        scramble_cmd();
    endtask

    task automatic run_cmd(input bit wr, input bit rd, input bit fail,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input logic [DW-1:0] rd_val, input int delay,
                           input bit inject);
        bit bus;
        bit bad;
        bit dropped;
        int n;
        int guard;
        int req_seen;
        bus = !fail && (wr != rd);
        push_reply(bus, wr, delay, rd_val);
        pulse_cmd(wr, rd, fail, a, wd);
        chk("busy_on_accept", busy, 1);
        chk("req_early", req, 0);
        @(posedge clk); #1;
        chk("req_latency", req, bus);
        chk("tx_valid_err", tx_valid, !bus);
        if (bus) begin
            n = 0;
            bad = 0;
            while (req && n < 50) begin
                if (we !== wr || reg_addr !== a) bad = 1;
                if (wr && reg_wdata !== wd) bad = 1;
                if (n == delay) begin
                    ack = 1'b1;
                    rdata_in = rd_val;
                end
                @(posedge clk); #1;
                ack = 1'b0;
                rdata_in = $urandom;
                n++;
            end
            chk("req_cycles", n, (delay < TO) ? delay + 1 : TO);
            chk("bus_stable", bad, 0);
            chk("tx_valid_after_bus", tx_valid, 1);
        end
        guard = 0;
        req_seen = 0;
        dropped = 0;
        while (busy && guard < 500) begin
            if (req) req_seen++;
            if (inject && !dropped && tx_valid) begin
                cmd_valid = 1'b1;
                @(posedge clk); #1;
                cmd_valid = 1'b0;
                scramble_cmd();
                chk("drop_pulse", cmd_drop, 1);
                dropped = 1;
                @(posedge clk); #1;
                chk("drop_one_cycle", cmd_drop, 0);
                guard += 2;
            end else begin
                @(posedge clk); #1;
                guard++;
            end
        end
        chk("busy_falls", guard < 500, 1);
        chk("req_after_bus", req_seen, 0);
        chk("tx_valid_idle", tx_valid, 0);
        chk("reply_drained", exp_q.size(), 0);
        if (inject) chk("drop_seen", dropped, 1);
    endtask

    task automatic run_reset(input bit in_resp);
        logic [DW-1:0] v;
        v = $urandom;
        if (in_resp) push_reply(1, 0, 0, v);
        pulse_cmd(0, 1, 0, 8'h33, 32'h0);
        @(posedge clk); #1;
        if (in_resp) begin
            ack = 1'b1;
            rdata_in = v;
            @(posedge clk); #1;
            ack = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk("rst_resp_active", tx_valid, 1);
        end else begin
            @(posedge clk); #1;
            chk("rst_bus_active", req, 1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        chk("rst_req", req, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            tx_ready = ($urandom_range(99) < ready_pct);
        end
    end

    // Monitor: pops on every accepted byte and checks stall stability
    initial begin
        logic [7:0] prev_data;
        bit prev_stall;
        prev_stall = 0;
        prev_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("tx_hold_valid", tx_valid, 1);
                    chk("tx_hold_data", tx_data, prev_data);
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL tx_extra: got %0h expected no byte",
                                 tx_data);
                    end else begin
                        chk("tx_byte", tx_data, exp_q.pop_front());
                    end
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data = tx_data;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state_req", req, 0);
        chk("rst_state_we", we, 0);
        chk("rst_state_addr", reg_addr, 0);
        chk("rst_state_wdata", reg_wdata, 0);
        chk("rst_state_txd", tx_data, 0);
        chk("rst_state_txv", tx_valid, 0);
        chk("rst_state_busy", busy, 0);
        chk("rst_state_drop", cmd_drop, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_cmd(1, 0, 0, 8'h12, 32'hDEADBEEF, 32'h0, 3, 0);
        run_cmd(0, 1, 0, 8'h05, 32'h0, 32'h0000A5F3, 0, 0);
        run_cmd(1, 0, 1, 8'h40, 32'h1234, 32'h0, 0, 0);
        run_cmd(1, 1, 0, 8'h41, 32'h5678, 32'h0, 0, 0);
        run_cmd(0, 0, 0, 8'h42, 32'h9ABC, 32'h0, 0, 0);
        run_cmd(0, 1, 0, 8'h07, 32'h0, 32'hCAFEF00D, TO, 0);
        run_cmd(1, 0, 0, 8'h08, 32'h0BADC0DE, 32'h0, TO, 0);
        run_cmd(0, 1, 0, 8'h09, 32'h0, 32'h89ABCDEF, TO - 1, 0);

        ready_pct = 30;
        run_cmd(0, 1, 0, 8'h0A, 32'h0, 32'h01234567, 1, 1);
        run_cmd(1, 0, 0, 8'h0B, 32'h55AA55AA, 32'h0, 2, 1);

        run_reset(0);
        run_cmd(1, 0, 0, 8'h21, 32'hFEEDFACE, 32'h0, 1, 0);
        run_reset(1);
        run_cmd(0, 1, 0, 8'h22, 32'h0, 32'h76543210, 2, 0);

        for (int i = 0; i < 40; i++) begin
            ready_pct = $urandom_range(20, 100);
            run_cmd(1'($urandom), 1'($urandom),
                    $urandom_range(9) == 0,
                    AW'($urandom), $urandom, $urandom,
                    $urandom_range(0, TO + 2),
                    1'($urandom));
        end

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
